hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core; replaces the fixed 24-bit/3-operand unit.
//  Per-source operand forwarding with EX/MEM-over-MEM/WB priority, gated by write-enable.
//  Multi-cycle load-use stall sequencer for data memory with LD_LAT-cycle latency.
//  Branch-flush masking, plus saturating stall/flush performance counters. Sits beside ID/EX and drives the bypass muxes and pipeline-register enables.
// PARAMETERS
//  DATA_W      24        datapath width
//  REG_W       4         register index width
//  NSRC        3         source operands per instruction (Ra,Rb,Rc)
//  LD_LAT      1         load latency in cycles; stall length on load-use (>=1)
//  NSTAGE      5         pipeline registers receiving flush bits
//  FLUSH_MASK  5'b01110  stages flushed on taken branch (bit i = stage i+1)
//  ZERO_REG    0         1: register 0 is hard-wired; never forwarded or stalled on
//  CNT_W       16        perf counter width
// PORTS
//  clk            in   1             core clock, rising edge
//  rst            in   1             synchronous, active-high reset
//  id_valid       in   1             instruction in ID/EX is real (not bubble)
//  src_idx        in   NSRC*REG_W    source register indices, src i at [i*REG_W +: REG_W]
//  src_used       in   NSRC          source i actually read
//  exmem_dst      in   REG_W         EX/MEM destination
//  exmem_wr       in   1             EX/MEM writes register file
//  exmem_is_load  in   1             EX/MEM instruction is a load
//  exmem_result   in   DATA_W        ALU result in EX/MEM
//  memwb_dst      in   REG_W         MEM/WB destination
//  memwb_wr       in   1             MEM/WB writes register file
//  memwb_result   in   DATA_W        writeback value
//  branch_taken   in   1             resolved taken branch this cycle
//  fwd_en         out  NSRC          source i bypassed
//  fwd_sel        out  NSRC*2        per source: 00 none, 01 EX/MEM, 10 MEM/WB
//  fwd_data       out  NSRC*DATA_W   bypass value (0 when fwd_en[i]=0)
//  stall          out  1             hold IF/ID and ID/EX, insert bubble into EX
//  flush          out  NSTAGE        per-stage flush
//  stall_cycles   out  CNT_W         saturating count of cycles with stall=1
//  flush_events   out  CNT_W         saturating count of cycles with branch_taken=1
// BEHAVIOUR
//  Forwarding (combinational, per source i):
//   - m_i = src_used[i] & !(ZERO_REG & src_idx_i==0).
//   - EX/MEM hit: m_i & exmem_wr & !exmem_is_load & src==exmem_dst -> sel 01, data exmem_result.
//   - Else MEM/WB hit: m_i & memwb_wr & src==memwb_dst -> sel 10, data memwb_result.
//   - Else sel 00, data 0. EX/MEM always wins over MEM/WB.
//  Load-use detect:
//   - luse = id_valid & exmem_wr & exmem_is_load & any(m_i & src_i==exmem_dst).
//  FSM {IDLE, HOLD}, down-counter cnt of $clog2(LD_LAT+1) bits:
//   - IDLE & luse & !branch_taken: stall=1 this cycle.
//     If LD_LAT>1: cnt<=LD_LAT-1, go to HOLD. Else stay in IDLE.
//   - HOLD: stall=1; cnt<=cnt-1. When cnt==1, return to IDLE next cycle. luse is ignored in HOLD.
//   - Total stall length per load-use event = LD_LAT cycles exactly.
//  Branch:
//   - branch_taken -> flush=FLUSH_MASK the same cycle (combinational).
//   - Forces stall=0 and next state IDLE with cnt<=0. Branch wins over luse and over HOLD.
//  Perf counters:
//   - Increment on the rising edge after a qualifying cycle; saturate at all-ones.
//  Reset:
//   - rst=1 -> state IDLE, cnt 0, counters 0.
//   - While rst=1: stall=0 and flush=0 (forced); fwd outputs remain combinational.
//   - rst mid-HOLD: stall drops in the rst cycle; no residual stall after release.
//  Widths: all compares are REG_W-bit equality; no arithmetic on data.
// STRUCTURE
//  hazard_pkg:
//   - typedef enum logic[1:0] fwd_sel_e {FWD_NONE, FWD_EXMEM, FWD_MEMWB}
//   - typedef enum logic hz_state_e {HZ_IDLE, HZ_HOLD}
//  Sub-module hazard_fwd_sel: one source's match and priority mux, instantiated NSRC times via generate.
//  FSM, stall counter and perf counters live in the top module.
// TESTING
//  1. src0=3 used, exmem_dst=3 wr=1 non-load, memwb_dst=3 wr=1
//     -> fwd_sel[0]=01, fwd_data[0]=exmem_result, stall=0.
//  2. src1=5, exmem_wr=0 (dst=5), memwb_dst=5 wr=1, result=24'hABCDEF
//     -> sel[1]=10, data=24'hABCDEF. Same case with memwb_wr=0 -> sel 00, data 0.
//  3. LD_LAT=3: exmem load dst=2, id src0=2, id_valid=1
//     -> stall high exactly 3 cycles; stall_cycles=3. Same with id_valid=0 -> no stall.
//  4. LD_LAT=3: load-use in cycle 0, branch_taken in cycle 1
//     -> flush=01110 in cycle 1, stall=0 from cycle 1, FSM IDLE.
//  5. ZERO_REG=1: src0=0, exmem_dst=0 wr=1 load -> fwd_en[0]=0, stall=0.
//  6. CNT_W=4: hold stall for 20 cycles -> stall_cycles=4'hF (saturated).
//     Assert rst mid-HOLD -> stall=0 in the rst cycle; counters 0 after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types for the pipeline hazard controller.
//   fwd_sel_e  : bypass source selector driven to the operand muxes
//   hz_state_e : load-use stall sequencer state
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
//   Forwarding decision for one source operand.
//   Ports:
//     src, used                    source register index and "actually read"
//     exmem_dst/wr/is_load/result  EX/MEM producer
//     memwb_dst/wr/result          MEM/WB producer
//     en, sel, data                bypass enable, selector, bypass value
//     exmem_match                  live source matches EX/MEM destination
//                                  (used by the top for load-use detection)
// ---------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int REG_W    = 4,
  parameter int ZERO_REG = 0
) (
  input  logic [REG_W-1:0]  src,
  input  logic              used,
  input  logic [REG_W-1:0]  exmem_dst,
  input  logic              exmem_wr,
  input  logic              exmem_is_load,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_W-1:0]  memwb_dst,
  input  logic              memwb_wr,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              en,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data,
  output logic              exmem_match
);

  logic     live;
  fwd_sel_e choice;

  // A hard-wired register 0 is never a real dependency.
  assign live = used & ~((ZERO_REG != 0) && (src == '0));

  // A load in EX/MEM has no data yet, so it cannot bypass; the stall
  // sequencer covers that case instead.
  always_comb begin
    choice = FWD_NONE;
    data   = '0;
    if (live && exmem_wr && !exmem_is_load && (src == exmem_dst)) begin
      choice = FWD_EXMEM;
      data   = exmem_result;
    end else if (live && memwb_wr && (src == memwb_dst)) begin
      choice = FWD_MEMWB;
      data   = memwb_result;
    end
  end

  assign sel         = choice;
  assign en          = (choice != FWD_NONE);
  assign exmem_match = live & (src == exmem_dst);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//   Pipeline hazard controller sitting beside ID/EX: per-source operand
//   forwarding, LD_LAT-cycle load-use stall sequencer, branch flush masking
//   and saturating stall/flush performance counters.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     id_valid                 ID/EX holds a real instruction
//     src_idx, src_used        packed source indices / read flags
//     exmem_*, memwb_*         producer info from EX/MEM and MEM/WB
//     branch_taken             resolved taken branch this cycle
//     fwd_en, fwd_sel, fwd_data  per-source bypass controls and data
//     stall                    hold IF/ID and ID/EX, bubble into EX
//     flush                    per-stage flush
//     stall_cycles, flush_events  saturating perf counters
// ---------------------------------------------------------------------------
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int              DATA_W     = 24,
  parameter int              REG_W      = 4,
  parameter int              NSRC       = 3,
  parameter int              LD_LAT     = 1,
  parameter int              NSTAGE     = 5,
  parameter logic [NSTAGE-1:0] FLUSH_MASK = 5'b01110,
  parameter int              ZERO_REG   = 0,
  parameter int              CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*REG_W-1:0]  src_idx,
  input  logic [NSRC-1:0]        src_used,
  input  logic [REG_W-1:0]       exmem_dst,
  input  logic                   exmem_wr,
  input  logic                   exmem_is_load,
  input  logic [DATA_W-1:0]      exmem_result,
  input  logic [REG_W-1:0]       memwb_dst,
  input  logic                   memwb_wr,
  input  logic [DATA_W-1:0]      memwb_result,
  input  logic                   branch_taken,
  output logic [NSRC-1:0]        fwd_en,
  output logic [NSRC*2-1:0]      fwd_sel,
  output logic [NSRC*DATA_W-1:0] fwd_data,
  output logic                   stall,
  output logic [NSTAGE-1:0]      flush,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_events
);

  localparam int               LAT_W      = $clog2(LD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LD_LAT - 1);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);

  logic [NSRC-1:0]  exmem_match;
  logic             luse;
  hz_state_e        state_reg, state_next;
  logic [LAT_W-1:0] cnt_reg, cnt_next;
  logic             stall_next;
  logic [CNT_W-1:0] stall_cycles_reg, flush_events_reg;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    hazard_fwd_sel #(
      .DATA_W   (DATA_W),
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG)
    ) u_fwd_sel (
      .src           (src_idx[gi*REG_W +: REG_W]),
      .used          (src_used[gi]),
      .exmem_dst     (exmem_dst),
      .exmem_wr      (exmem_wr),
      .exmem_is_load (exmem_is_load),
      .exmem_result  (exmem_result),
      .memwb_dst     (memwb_dst),
      .memwb_wr      (memwb_wr),
      .memwb_result  (memwb_result),
      .en            (fwd_en[gi]),
      .sel           (fwd_sel[gi*2 +: 2]),
      .data          (fwd_data[gi*DATA_W +: DATA_W]),
      .exmem_match   (exmem_match[gi])
    );
  end

  assign luse = id_valid & exmem_wr & exmem_is_load & (|exmem_match);

  // The first stall cycle is spent in IDLE; HOLD covers the remaining
  // LD_LAT-1 cycles, so a single-cycle latency never leaves IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_next = 1'b0;
    if (branch_taken) begin
      state_next = HZ_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        HZ_IDLE: begin
          if (luse) begin
            stall_next = 1'b1;
            if (LD_LAT > 1) begin
              state_next = HZ_HOLD;
              cnt_next   = LAT_RELOAD;
            end
          end
        end
        HZ_HOLD: begin
          stall_next = 1'b1;
          cnt_next   = cnt_reg - LAT_ONE;
          if (cnt_reg == LAT_ONE) begin
            state_next = HZ_IDLE;
          end
        end
        default: begin
          state_next = HZ_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Reset masks the control outputs immediately, before state is cleared.
  assign stall = stall_next & ~rst;
  assign flush = (branch_taken && !rst) ? FLUSH_MASK : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= HZ_IDLE;
      cnt_reg          <= '0;
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (stall && (stall_cycles_reg != '1)) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      end
      if (branch_taken && (flush_events_reg != '1)) begin
        flush_events_reg <= flush_events_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//   Two instances share one stimulus stream: dut_a (LD_LAT=3, ZERO_REG=1,
//   CNT_W=4) and dut_b (LD_LAT=1, ZERO_REG=0, CNT_W=16). The driver computes
//   each cycle's expected outputs from a "remaining stall cycles" model and
//   queues them; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [11:0] src_idx;
  logic [2:0]  src_used;
  logic [3:0]  exmem_dst;
  logic        exmem_wr;
  logic        exmem_is_load;
  logic [23:0] exmem_result;
  logic [3:0]  memwb_dst;
  logic        memwb_wr;
  logic [23:0] memwb_result;
  logic        branch_taken;

  logic [2:0]  fwd_en_a, fwd_en_b;
  logic [5:0]  fwd_sel_a, fwd_sel_b;
  logic [71:0] fwd_data_a, fwd_data_b;
  logic        stall_a, stall_b;
  logic [4:0]  flush_a, flush_b;
  logic [3:0]  stall_cycles_a, flush_events_a;
  logic [15:0] stall_cycles_b, flush_events_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0]  en;
    logic [5:0]  sel;
    logic [71:0] data;
    logic        stall;
    logic [4:0]  flush;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int rem_a = 0, sc_a = 0, fe_a = 0;
  int rem_b = 0, sc_b = 0, fe_b = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.LD_LAT(3), .ZERO_REG(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src_idx(src_idx), .src_used(src_used),
    .exmem_dst(exmem_dst), .exmem_wr(exmem_wr), .exmem_is_load(exmem_is_load),
    .exmem_result(exmem_result), .memwb_dst(memwb_dst), .memwb_wr(memwb_wr),
    .memwb_result(memwb_result), .branch_taken(branch_taken),
    .fwd_en(fwd_en_a), .fwd_sel(fwd_sel_a), .fwd_data(fwd_data_a), .stall(stall_a),
    .flush(flush_a), .stall_cycles(stall_cycles_a), .flush_events(flush_events_a)
  );

  hazard_ctrl_unit #(.LD_LAT(1), .ZERO_REG(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src_idx(src_idx), .src_used(src_used),
    .exmem_dst(exmem_dst), .exmem_wr(exmem_wr), .exmem_is_load(exmem_is_load),
    .exmem_result(exmem_result), .memwb_dst(memwb_dst), .memwb_wr(memwb_wr),
    .memwb_result(memwb_result), .branch_taken(branch_taken),
    .fwd_en(fwd_en_b), .fwd_sel(fwd_sel_b), .fwd_data(fwd_data_b), .stall(stall_b),
    .flush(flush_b), .stall_cycles(stall_cycles_b), .flush_events(flush_events_b)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one cycle of expected behaviour from the current inputs.
  task automatic model_cycle(input bit zr, input int lat, input int cmax,
                             inout int rem, inout int sc, inout int fe, output exp_t e);
    bit hit;
    bit luse;
    hit    = 1'b0;
    e.en   = '0;
    e.sel  = '0;
    e.data = '0;
    e.sc   = 32'(sc);
    e.fe   = 32'(fe);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] s;
      bit m;
      s = src_idx[i*4 +: 4];
      m = src_used[i] && !(zr && s == 4'd0);
      if (m && exmem_wr && !exmem_is_load && s == exmem_dst) begin
        e.en[i] = 1'b1; e.sel[i*2 +: 2] = 2'b01; e.data[i*24 +: 24] = exmem_result;
      end else if (m && memwb_wr && s == memwb_dst) begin
        e.en[i] = 1'b1; e.sel[i*2 +: 2] = 2'b10; e.data[i*24 +: 24] = memwb_result;
      end
      if (m && s == exmem_dst) hit = 1'b1;
    end
    luse = id_valid && exmem_wr && exmem_is_load && hit;
    if (rst || branch_taken) e.stall = 1'b0;
    else                     e.stall = (rem > 0) || luse;
    e.flush = (!rst && branch_taken) ? 5'b01110 : 5'b00000;
    if (rst) begin
      rem = 0; sc = 0; fe = 0;
    end else begin
      if (e.stall && sc < cmax) sc++;
      if (branch_taken && fe < cmax) fe++;
      if (branch_taken)   rem = 0;
      else if (rem > 0)   rem--;
      else if (luse)      rem = lat - 1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic commit();
    exp_t ea, eb;
    model_cycle(1'b1, 3, 15,    rem_a, sc_a, fe_a, ea);
    model_cycle(1'b0, 1, 65535, rem_b, sc_b, fe_b, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; id_valid = 1'b0; src_idx = '0; src_used = '0;
    exmem_dst = '0; exmem_wr = 1'b0; exmem_is_load = 1'b0; exmem_result = '0;
    memwb_dst = '0; memwb_wr = 1'b0; memwb_result = '0; branch_taken = 1'b0;
  endtask

  task automatic set_load_use();
    clear_inputs();
    id_valid = 1'b1; src_idx[3:0] = 4'd2; src_used = 3'b001;
    exmem_dst = 4'd2; exmem_wr = 1'b1; exmem_is_load = 1'b1;
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [2:0] en, input logic [5:0] sel,
                     input logic [71:0] data, input logic st, input logic [4:0] fl,
                     input logic [31:0] sc, input logic [31:0] fe);
    chk({tag, "_fwd_en"},   72'(en),   72'(e.en));
    chk({tag, "_fwd_sel"},  72'(sel),  72'(e.sel));
    chk({tag, "_fwd_data"}, data,      e.data);
    chk({tag, "_stall"},    72'(st),   72'(e.stall));
    chk({tag, "_flush"},    72'(fl),   72'(e.flush));
    chk({tag, "_stall_cycles"}, 72'(sc), 72'(e.sc));
    chk({tag, "_flush_events"}, 72'(fe), 72'(e.fe));
  endtask

  // Monitor: every cycle presents a response; pop and compare.
  always @(negedge clk) begin
    if (qa.size() > 0 && qb.size() > 0) begin
      exp_t ea, eb;
      ea = qa.pop_front();
      eb = qb.pop_front();
      cmp("a", ea, fwd_en_a, fwd_sel_a, fwd_data_a, stall_a, flush_a,
          32'(stall_cycles_a), 32'(flush_events_a));
      cmp("b", eb, fwd_en_b, fwd_sel_b, fwd_data_b, stall_b, flush_b,
          32'(stall_cycles_b), 32'(flush_events_b));
      $display("cyc %0d rst=%b br=%b stall a/b=%b/%b flush_a=%b sc_a=%0d fe_a=%0d sel_a=%b",
               cyc, rst, branch_taken, stall_a, stall_b, flush_a,
               stall_cycles_a, flush_events_a, fwd_sel_a);
      cyc++;
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset cycle
    next_cycle(); clear_inputs(); rst = 1'b1; commit(); settle();
    chk("reset_stall", 72'(stall_a), 72'(0));
    chk("reset_flush", 72'(flush_a), 72'(0));

    // EX/MEM wins over MEM/WB
    next_cycle(); clear_inputs();
    src_idx[3:0] = 4'd3; src_used = 3'b001;
    exmem_dst = 4'd3; exmem_wr = 1'b1; exmem_result = 24'h123456;
    memwb_dst = 4'd3; memwb_wr = 1'b1; memwb_result = 24'h654321;
    commit(); settle();
    chk("t1_sel0",  72'(fwd_sel_a[1:0]), 72'(2'b01));
    chk("t1_data0", 72'(fwd_data_a[23:0]), 72'(24'h123456));
    chk("t1_stall", 72'(stall_a), 72'(0));

    // MEM/WB only, then nothing
    next_cycle(); clear_inputs();
    src_idx[7:4] = 4'd5; src_used = 3'b010;
    exmem_dst = 4'd5; memwb_dst = 4'd5; memwb_wr = 1'b1; memwb_result = 24'hABCDEF;
    commit(); settle();
    chk("t2_sel1",  72'(fwd_sel_a[3:2]), 72'(2'b10));
    chk("t2_data1", 72'(fwd_data_a[47:24]), 72'(24'hABCDEF));
    next_cycle(); memwb_wr = 1'b0; commit(); settle();
    chk("t2_sel1_none",  72'(fwd_sel_a[3:2]), 72'(2'b00));
    chk("t2_data1_zero", 72'(fwd_data_a[47:24]), 72'(0));

    // Load-use: exactly LD_LAT=3 stall cycles
    next_cycle(); clear_inputs(); rst = 1'b1; commit();
    next_cycle(); set_load_use(); commit(); settle();
    chk("t3_stall_c0", 72'(stall_a), 72'(1));
    next_cycle(); clear_inputs(); commit(); settle();
    chk("t3_stall_c1", 72'(stall_a), 72'(1));
    next_cycle(); commit(); settle();
    chk("t3_stall_c2", 72'(stall_a), 72'(1));
    next_cycle(); commit(); settle();
    chk("t3_stall_c3", 72'(stall_a), 72'(0));
    chk("t3_stall_cycles", 72'(stall_cycles_a), 72'(3));
    next_cycle(); set_load_use(); id_valid = 1'b0; commit(); settle();
    chk("t3_bubble_no_stall", 72'(stall_a), 72'(0));

    // Branch during HOLD
    next_cycle(); set_load_use(); commit();
    next_cycle(); clear_inputs(); branch_taken = 1'b1; commit(); settle();
    chk("t4_flush", 72'(flush_a), 72'(5'b01110));
    chk("t4_stall", 72'(stall_a), 72'(0));
    next_cycle(); clear_inputs(); commit(); settle();
    chk("t4_idle", 72'(stall_a), 72'(0));

    // Register 0 on a load: ignored only where hard-wired
    next_cycle(); clear_inputs();
    id_valid = 1'b1; src_used = 3'b001; exmem_wr = 1'b1; exmem_is_load = 1'b1;
    commit(); settle();
    chk("t5_fwd_en0", 72'(fwd_en_a[0]), 72'(0));
    chk("t5_stall_a", 72'(stall_a), 72'(0));
    chk("t5_stall_b", 72'(stall_b), 72'(1));

    // Saturation, then reset mid-HOLD
    for (int k = 0; k < 20; k++) begin
      next_cycle(); set_load_use(); commit();
    end
    next_cycle(); clear_inputs(); commit(); settle();
    chk("t6_saturated", 72'(stall_cycles_a), 72'(4'hF));
    next_cycle(); set_load_use(); commit();
    next_cycle(); clear_inputs(); rst = 1'b1; commit(); settle();
    chk("t6_rst_stall", 72'(stall_a), 72'(0));
    next_cycle(); clear_inputs(); commit(); settle();
    chk("t6_post_stall", 72'(stall_a), 72'(0));
    chk("t6_post_sc", 72'(stall_cycles_a), 72'(0));
    chk("t6_post_fe", 72'(flush_events_a), 72'(0));

    // Random traffic with small register range to provoke hazards
    for (int k = 0; k < 400; k++) begin
      next_cycle();
      rst           = ($urandom_range(0, 49) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) src_idx[i*4 +: 4] = 4'($urandom_range(0, 3));
      src_used      = 3'($urandom_range(0, 7));
      exmem_dst     = 4'($urandom_range(0, 3));
      exmem_wr      = 1'($urandom_range(0, 1));
      exmem_is_load = 1'($urandom_range(0, 1));
      exmem_result  = 24'($urandom);
      memwb_dst     = 4'($urandom_range(0, 3));
      memwb_wr      = 1'($urandom_range(0, 1));
      memwb_result  = 24'($urandom);
      branch_taken  = ($urandom_range(0, 7) == 0);
      commit();
    end

    next_cycle(); clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drain", 72'(qa.size() + qb.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
